// File: rtl/mem_hold_arbiter.sv
// Memory-side responder for the video DMA hold protocol: halts the CPU, waits for BA,
// then hands the shared asynchronous SRAM to the DMA master until hold is dropped.
module mem_hold_arbiter #(
  parameter int HALT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        vramcs,
  input  logic [15:0] vaddr,
  output logic [7:0]  vdata,
  output logic        hlda,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_rw,
  input  logic        cpu_vma,
  output logic [7:0]  cpu_di,
  output logic        cpu_halt,
  input  logic        cpu_ba,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_do,
  input  logic [7:0]  mem_di,
  output logic        mem_we,
  output logic        mem_ce,
  output logic        timeout,
  output logic        late_grant,
  output logic [1:0]  dbg_state
);

  // Handshake: hold is a level request and hlda a level acknowledge; the master may
  // strobe vramcs only while hlda is high, and hold must stay high for the whole burst.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HALT_REQ = 2'd1,
    ST_GRANT    = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(HALT_TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cpu_halt   <= 1'b0;
      hlda       <= 1'b0;
      timeout    <= 1'b0;
      late_grant <= 1'b0;
      wait_cnt   <= 8'd0;
    end else begin
      if (vramcs && !hlda) late_grant <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (hold) begin
            state    <= ST_HALT_REQ;
            cpu_halt <= 1'b1;
            wait_cnt <= 8'd0;
          end
        end
        ST_HALT_REQ: begin
          if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
          if (!cpu_ba && wait_cnt == TIMEOUT_CNT) timeout <= 1'b1;
          // A dropped request wins over a BA arriving in the same cycle: no grant.
          if (!hold) begin
            state    <= ST_RELEASE;
            cpu_halt <= 1'b0;
          end else if (cpu_ba) begin
            state <= ST_GRANT;
            hlda  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (!hold) begin
            state    <= ST_RELEASE;
            cpu_halt <= 1'b0;
            hlda     <= 1'b0;
          end
        end
        ST_RELEASE: begin
          state    <= ST_IDLE;
          cpu_halt <= 1'b0;
          hlda     <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          cpu_halt <= 1'b0;
          hlda     <= 1'b0;
        end
      endcase
    end
  end

  // DMA side is read-only, so mem_we can only ever come from the CPU.
  always_comb begin
    mem_addr = cpu_addr;
    mem_do   = cpu_do;
    mem_ce   = cpu_vma;
    mem_we   = cpu_vma & ~cpu_rw;
    cpu_di   = mem_di;
    vdata    = 8'hFF;
    if (hlda) begin
      mem_addr = vaddr;
      mem_ce   = vramcs;
      mem_we   = 1'b0;
      cpu_di   = 8'hFF;
      vdata    = mem_di;
    end
  end

endmodule

// File: tb/tb_mem_hold_arbiter.sv
// Directed bench for mem_hold_arbiter: inputs change 1ns after posedge, outputs are
// sampled at negedge; a small SRAM model answers reads combinationally.
module tb_mem_hold_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        vramcs;
  logic [15:0] vaddr;
  logic [7:0]  vdata;
  logic        hlda;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_do;
  logic        cpu_rw;
  logic        cpu_vma;
  logic [7:0]  cpu_di;
  logic        cpu_halt;
  logic        cpu_ba;
  logic [15:0] mem_addr;
  logic [7:0]  mem_do;
  logic [7:0]  mem_di;
  logic        mem_we;
  logic        mem_ce;
  logic        timeout;
  logic        late_grant;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_HALT = 2'd1, S_GRANT = 2'd2, S_REL = 2'd3;

  always #5 clk = ~clk;

  mem_hold_arbiter #(.HALT_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .hold(hold), .vramcs(vramcs), .vaddr(vaddr), .vdata(vdata),
    .hlda(hlda), .cpu_addr(cpu_addr), .cpu_do(cpu_do), .cpu_rw(cpu_rw), .cpu_vma(cpu_vma),
    .cpu_di(cpu_di), .cpu_halt(cpu_halt), .cpu_ba(cpu_ba), .mem_addr(mem_addr),
    .mem_do(mem_do), .mem_di(mem_di), .mem_we(mem_we), .mem_ce(mem_ce),
    .timeout(timeout), .late_grant(late_grant), .dbg_state(dbg_state)
  );

  // SRAM model: 0x2000..0x200F is a fixed pattern 0xA0+offset, the rest is writable.
  logic [7:0] sram [0:65535];
  assign mem_di = (mem_addr[15:4] == 12'h200) ? (8'hA0 + {4'h0, mem_addr[3:0]}) : sram[mem_addr];
  always @(posedge clk) if (mem_ce && mem_we) sram[mem_addr] <= mem_do;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; hold = 1'b0; cpu_ba = 1'b0; vramcs = 1'b0; cpu_vma = 1'b0;
    next_cycle;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; hold = 1'b1; cpu_ba = 1'b1;
    next_cycle;
    next_cycle;
    mid;
    tests_run++; if (hlda !== 1'b0) begin tests_failed++; $display("FAIL reset_hlda: got %b expected 0", hlda); end
    tests_run++; if (cpu_halt !== 1'b0) begin tests_failed++; $display("FAIL reset_halt: got %b expected 0", cpu_halt); end
    tests_run++; if ({timeout, late_grant} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00", {timeout, late_grant}); end
    tests_run++; if (dbg_state !== S_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
    tests_run++; if ({mem_ce, mem_we} !== 2'b00) begin tests_failed++; $display("FAIL reset_mem_ctl: got %b expected 00", {mem_ce, mem_we}); end
    rst = 1'b0;
    next_cycle;
    mid;
    tests_run++; if ({cpu_halt, hlda} !== 2'b10) begin tests_failed++; $display("FAIL post_reset_halt: got %b expected 10", {cpu_halt, hlda}); end
    next_cycle;
    mid;
    tests_run++; if ({cpu_halt, hlda} !== 2'b11) begin tests_failed++; $display("FAIL post_reset_grant: got %b expected 11", {cpu_halt, hlda}); end
    hold = 1'b0;
    next_cycle;
    cpu_ba = 1'b0;
    mid;
    tests_run++; if ({cpu_halt, hlda, dbg_state} !== {2'b00, S_REL}) begin tests_failed++; $display("FAIL release: got %b expected 0011", {cpu_halt, hlda, dbg_state}); end
    next_cycle;
    mid;
    tests_run++; if (dbg_state !== S_IDLE) begin tests_failed++; $display("FAIL release_to_idle: got %0d expected %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_dma_burst;
    logic [7:0] exp_v;
    hold = 1'b1; cpu_ba = 1'b0;
    next_cycle;
    cpu_ba = 1'b1;
    next_cycle;
    mid;
    tests_run++; if (hlda !== 1'b1) begin tests_failed++; $display("FAIL burst_grant: got %b expected 1", hlda); end
    for (int i = 0; i < 4; i++) begin
      next_cycle;
      vramcs = 1'b1;
      vaddr = 16'h2000 + 16'(i);
      exp_v = 8'hA0 + 8'(i);
      mid;
      tests_run++; if (vdata !== exp_v) begin tests_failed++; $display("FAIL burst_vdata[%0d]: got %h expected %h", i, vdata, exp_v); end
      tests_run++; if ({mem_ce, mem_we} !== 2'b10) begin tests_failed++; $display("FAIL burst_mem_ctl[%0d]: got %b expected 10", i, {mem_ce, mem_we}); end
      tests_run++; if (mem_addr !== vaddr) begin tests_failed++; $display("FAIL burst_addr[%0d]: got %h expected %h", i, mem_addr, vaddr); end
      tests_run++; if (cpu_di !== 8'hFF) begin tests_failed++; $display("FAIL burst_cpu_di[%0d]: got %h expected ff", i, cpu_di); end
    end
    next_cycle;
    vramcs = 1'b0; hold = 1'b0;
    mid;
    tests_run++; if (late_grant !== 1'b0) begin tests_failed++; $display("FAIL burst_late_grant: got %b expected 0", late_grant); end
    tests_run++; if (hlda !== 1'b1) begin tests_failed++; $display("FAIL burst_hold_until_drop: got %b expected 1", hlda); end
    next_cycle;
    cpu_ba = 1'b0;
    mid;
    tests_run++; if (hlda !== 1'b0) begin tests_failed++; $display("FAIL burst_release: got %b expected 0", hlda); end
    next_cycle;
  endtask

  task automatic test_slow_ba;
    hold = 1'b1; cpu_ba = 1'b0;
    next_cycle;
    for (int j = 1; j <= 20; j++) begin
      next_cycle;
      mid;
      if (j == 14) begin
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_early: got %b expected 0", timeout); end
      end
      if (j == 16) begin
        tests_run++; if (timeout !== 1'b1) begin tests_failed++; $display("FAIL timeout_set: got %b expected 1", timeout); end
      end
      if (j == 20) begin
        tests_run++; if ({cpu_halt, hlda} !== 2'b10) begin tests_failed++; $display("FAIL slow_ba_waiting: got %b expected 10", {cpu_halt, hlda}); end
      end
    end
    cpu_ba = 1'b1;
    next_cycle;
    mid;
    tests_run++; if (hlda !== 1'b1) begin tests_failed++; $display("FAIL slow_ba_grant: got %b expected 1", hlda); end
    hold = 1'b0;
    next_cycle;
    cpu_ba = 1'b0;
    next_cycle;
    mid;
    tests_run++; if (timeout !== 1'b1) begin tests_failed++; $display("FAIL timeout_sticky: got %b expected 1", timeout); end
    do_reset;
    mid;
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_cleared: got %b expected 0", timeout); end
  endtask

  task automatic test_early_vramcs;
    hold = 1'b1; cpu_ba = 1'b0;
    next_cycle;
    vramcs = 1'b1; vaddr = 16'h2002; cpu_vma = 1'b0; cpu_addr = 16'h0100;
    mid;
    tests_run++; if (mem_ce !== 1'b0) begin tests_failed++; $display("FAIL early_mem_ce: got %b expected 0", mem_ce); end
    tests_run++; if (mem_addr !== 16'h0100) begin tests_failed++; $display("FAIL early_mem_addr: got %h expected 0100", mem_addr); end
    next_cycle;
    vramcs = 1'b0; hold = 1'b0;
    mid;
    tests_run++; if (late_grant !== 1'b1) begin tests_failed++; $display("FAIL late_grant_set: got %b expected 1", late_grant); end
    next_cycle;
    mid;
    tests_run++; if ({hlda, dbg_state} !== {1'b0, S_REL}) begin tests_failed++; $display("FAIL early_abort: got %b expected 011", {hlda, dbg_state}); end
    next_cycle;
    mid;
    tests_run++; if (late_grant !== 1'b1) begin tests_failed++; $display("FAIL late_grant_sticky: got %b expected 1", late_grant); end
    do_reset;
  endtask

  task automatic test_cpu_traffic;
    next_cycle;
    cpu_vma = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h1234; cpu_do = 8'h55;
    mid;
    tests_run++; if ({mem_ce, mem_we} !== 2'b11) begin tests_failed++; $display("FAIL cpu_write_ctl: got %b expected 11", {mem_ce, mem_we}); end
    tests_run++; if ({mem_addr, mem_do} !== {16'h1234, 8'h55}) begin tests_failed++; $display("FAIL cpu_write_bus: got %h expected 123455", {mem_addr, mem_do}); end
    next_cycle;
    cpu_rw = 1'b1; cpu_do = 8'h00;
    mid;
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL cpu_read_we: got %b expected 0", mem_we); end
    tests_run++; if (cpu_di !== 8'h55) begin tests_failed++; $display("FAIL cpu_read_data: got %h expected 55", cpu_di); end
    tests_run++; if (vdata !== 8'hFF) begin tests_failed++; $display("FAIL cpu_vdata_idle: got %h expected ff", vdata); end
    next_cycle;
    cpu_vma = 1'b0;
  endtask

  task automatic test_abort_rerequest;
    hold = 1'b1; cpu_ba = 1'b0;
    next_cycle;
    hold = 1'b0; cpu_ba = 1'b1;
    mid;
    tests_run++; if ({cpu_halt, hlda} !== 2'b10) begin tests_failed++; $display("FAIL abort_halt: got %b expected 10", {cpu_halt, hlda}); end
    next_cycle;
    hold = 1'b1; cpu_ba = 1'b0;
    mid;
    tests_run++; if ({cpu_halt, hlda, dbg_state} !== {2'b00, S_REL}) begin tests_failed++; $display("FAIL abort_release: got %b expected 0011", {cpu_halt, hlda, dbg_state}); end
    next_cycle;
    mid;
    tests_run++; if ({cpu_halt, hlda, dbg_state} !== {2'b00, S_IDLE}) begin tests_failed++; $display("FAIL rerequest_idle: got %b expected 0000", {cpu_halt, hlda, dbg_state}); end
    next_cycle;
    cpu_ba = 1'b1;
    mid;
    tests_run++; if ({cpu_halt, hlda, dbg_state} !== {2'b10, S_HALT}) begin tests_failed++; $display("FAIL rerequest_halt: got %b expected 1001", {cpu_halt, hlda, dbg_state}); end
    next_cycle;
    mid;
    tests_run++; if (hlda !== 1'b1) begin tests_failed++; $display("FAIL rerequest_grant: got %b expected 1", hlda); end
  endtask

  task automatic test_reset_mid_burst;
    next_cycle;
    vramcs = 1'b1; vaddr = 16'h2001;
    mid;
    tests_run++; if (vdata !== 8'hA1) begin tests_failed++; $display("FAIL mid_burst_vdata: got %h expected a1", vdata); end
    rst = 1'b1;
    next_cycle;
    vramcs = 1'b0; hold = 1'b0; cpu_ba = 1'b0;
    mid;
    tests_run++; if ({cpu_halt, hlda, dbg_state} !== {2'b00, S_IDLE}) begin tests_failed++; $display("FAIL mid_burst_reset: got %b expected 0000", {cpu_halt, hlda, dbg_state}); end
    tests_run++; if (late_grant !== 1'b0) begin tests_failed++; $display("FAIL mid_burst_flags: got %b expected 0", late_grant); end
    rst = 1'b0;
    next_cycle;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; vramcs = 1'b0; vaddr = 16'h0000; cpu_addr = 16'h0000;
    cpu_do = 8'h00; cpu_rw = 1'b1; cpu_vma = 1'b0; cpu_ba = 1'b0;
    test_reset;
    test_dma_burst;
    test_slow_ba;
    test_cpu_traffic;
    test_early_vramcs;
    test_abort_rerequest;
    test_reset_mid_burst;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
